// File: rtl/kmkz_exceptions.sv
`default_nettype none
// ============================================================================
// Module      : kmkz_exceptions
// Description : Machine-mode trap controller for Kamikaze-uRV. Owns mstatus,
//               mip, mie, mepc, mcause and arbitrates exception/IRQ/MRET.
//               Optional macro KMKZ_MTVEC_EN adds a writable mtvec.
// Revision    : 1.0 - initial release
// ============================================================================
module kmkz_exceptions #(
  parameter logic [31:0] TRAP_VECTOR     = 32'h00000008,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        x_valid_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        x_is_mret_i,
  input  logic        x_is_csr_i,
  input  logic [11:0] x_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        irq_i,
  input  logic        timer_irq_i,
  output logic        x_redirect_o,
  output logic [31:0] x_redirect_pc_o,
  output logic        x_trap_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
`ifdef KMKZ_MTVEC_EN
  ,
  output logic [31:0] csr_mtvec_o
`endif
);

  localparam logic [11:0] c_csr_mstatus = 12'h300;
  localparam logic [11:0] c_csr_mie     = 12'h304;
  localparam logic [11:0] c_csr_mtvec   = 12'h305;
  localparam logic [11:0] c_csr_mepc    = 12'h341;
  localparam logic [11:0] c_csr_mcause  = 12'h342;
  localparam logic [11:0] c_csr_mip     = 12'h344;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [2:0]  r_mie_en;      // {MEIE, MTIE, MSIE}
  logic        r_msip;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [IRQ_SYNC_STAGES-1:0] r_irq_sync;

  logic        w_irq_ext;
  logic [2:0]  w_pend;        // {external, timer, software}
  logic        w_irq_ok;
  logic        w_go;
  logic        w_exc;
  logic        w_irq;
  logic        w_mret;
  logic        w_trap;
  logic        w_csr_we;
  logic [3:0]  w_irq_code;
  logic [31:0] w_vector;

  // Two-flop style synchronizer for the asynchronous external interrupt.
  generate
    if (IRQ_SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_irq_sync <= '0;
        end else begin
          r_irq_sync <= irq_i;
        end
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_irq_sync <= '0;
        end else begin
          r_irq_sync <= {r_irq_sync[IRQ_SYNC_STAGES-2:0], irq_i};
        end
      end
    end
  endgenerate

  assign w_irq_ext = r_irq_sync[IRQ_SYNC_STAGES-1];

  assign w_pend   = {w_irq_ext & r_mie_en[2], timer_irq_i & r_mie_en[1], r_msip & r_mie_en[0]};
  assign w_irq_ok = r_mstatus_mie && (w_pend != 3'b000);

  assign w_go     = !x_stall_i && !x_kill_i && x_valid_i;
  assign w_exc    = w_go && x_exception_i;
  assign w_irq    = w_go && !x_exception_i && w_irq_ok;
  assign w_mret   = w_go && !w_exc && !w_irq && x_is_mret_i;
  assign w_trap   = w_exc || w_irq;
  assign w_csr_we = w_go && x_is_csr_i && !w_trap && !w_mret;

  // External outranks software, which outranks timer.
  always_comb begin
    w_irq_code = 4'd7;
    if (w_pend[2]) begin
      w_irq_code = 4'd11;
    end else if (w_pend[0]) begin
      w_irq_code = 4'd3;
    end
  end

`ifdef KMKZ_MTVEC_EN
  logic [31:0] r_mtvec;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtvec <= {TRAP_VECTOR[31:2], 2'b00};
    end else if (w_csr_we && (x_csr_sel_i == c_csr_mtvec)) begin
      r_mtvec <= {x_csr_write_value_i[31:2], 2'b00};
    end
  end

  assign w_vector    = r_mtvec;
  assign csr_mtvec_o = r_mtvec;
`else
  assign w_vector = TRAP_VECTOR;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_en       <= 3'b000;
      r_msip         <= 1'b0;
      r_mepc         <= 32'h0;
      r_mcause       <= 32'h0;
    end else if (w_trap) begin
      // The interrupted instruction has not executed, so it re-runs after MRET.
      r_mepc         <= x_pc_i;
      r_mcause       <= w_exc ? {28'b0, x_exception_cause_i} : {1'b1, 27'b0, w_irq_code};
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (x_csr_sel_i)
        c_csr_mstatus: begin
          r_mstatus_mie  <= x_csr_write_value_i[3];
          r_mstatus_mpie <= x_csr_write_value_i[7];
        end
        c_csr_mie: begin
          r_mie_en <= {x_csr_write_value_i[11], x_csr_write_value_i[7], x_csr_write_value_i[3]};
        end
        c_csr_mepc: begin
          r_mepc <= {x_csr_write_value_i[31:1], 1'b0};
        end
        c_csr_mcause: begin
          r_mcause <= x_csr_write_value_i;
        end
        c_csr_mip: begin
          r_msip <= x_csr_write_value_i[3];
        end
        default: begin
        end
      endcase
    end
  end

  assign x_trap_o        = w_trap;
  assign x_redirect_o    = w_trap || w_mret;
  assign x_redirect_pc_o = w_trap ? w_vector : r_mepc;

  assign csr_mstatus_o = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign csr_mip_o     = {20'b0, w_irq_ext, 3'b0, timer_irq_i, 3'b0, r_msip, 3'b0};
  assign csr_mie_o     = {20'b0, r_mie_en[2], 3'b0, r_mie_en[1], 3'b0, r_mie_en[0], 3'b0};
  assign csr_mepc_o    = r_mepc;
  assign csr_mcause_o  = r_mcause;

endmodule
`default_nettype wire

// File: tb/tb_kmkz_exceptions.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmkz_exceptions
// Description : Directed scenarios plus randomized traffic against a
//               behavioural trap model for kmkz_exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmkz_exceptions;

  localparam int          c_sync = 2;
  localparam logic [31:0] c_vec  = 32'h00000008;

  logic        clk;
  logic        rst;
  logic        x_stall, x_kill, x_valid;
  logic [31:0] x_pc;
  logic        x_exception;
  logic [3:0]  x_cause;
  logic        x_is_mret, x_is_csr;
  logic [11:0] x_csr_sel;
  logic [31:0] x_csr_wval;
  logic        irq, timer_irq;
  logic        redirect, trap;
  logic [31:0] redirect_pc, mstatus, mip, mie, mepc, mcause;
`ifdef KMKZ_MTVEC_EN
  logic [31:0] mtvec;
`endif

  int checks = 0;
  int errors = 0;

  kmkz_exceptions #(.TRAP_VECTOR(c_vec), .IRQ_SYNC_STAGES(c_sync)) dut (
    .clk_i(clk), .rst_i(rst),
    .x_stall_i(x_stall), .x_kill_i(x_kill), .x_valid_i(x_valid),
    .x_pc_i(x_pc), .x_exception_i(x_exception), .x_exception_cause_i(x_cause),
    .x_is_mret_i(x_is_mret), .x_is_csr_i(x_is_csr), .x_csr_sel_i(x_csr_sel),
    .x_csr_write_value_i(x_csr_wval), .irq_i(irq), .timer_irq_i(timer_irq),
    .x_redirect_o(redirect), .x_redirect_pc_o(redirect_pc), .x_trap_o(trap),
    .csr_mstatus_o(mstatus), .csr_mip_o(mip), .csr_mie_o(mie),
    .csr_mepc_o(mepc), .csr_mcause_o(mcause)
`ifdef KMKZ_MTVEC_EN
    , .csr_mtvec_o(mtvec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: architectural view of the trap registers.
  bit          m_mie, m_mpie, m_msip;
  logic [31:0] m_mie_reg, m_mepc, m_mcause, m_mtvec;
  bit          m_hist[$];

  function automatic logic [31:0] model_mip();
    return (32'(m_hist[c_sync-1]) << 11) | (32'(timer_irq) << 7) | (32'(m_msip) << 3);
  endfunction

  function automatic logic [31:0] model_mstatus();
    return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
  endfunction

  function automatic logic [31:0] model_vector();
`ifdef KMKZ_MTVEC_EN
    return m_mtvec;
`else
    return c_vec;
`endif
  endfunction

  task automatic model_comb(output bit o_trap, output bit o_redir, output logic [31:0] o_pc,
                            output bit o_irq, output bit o_mret);
    logic [31:0] pend;
    bit          go;
    pend   = model_mip() & m_mie_reg;
    go     = x_valid && !x_stall && !x_kill;
    o_irq  = go && !x_exception && m_mie && (pend != 0);
    o_trap = (go && x_exception) || o_irq;
    o_mret = go && !o_trap && x_is_mret;
    o_redir = o_trap || o_mret;
    o_pc   = o_trap ? model_vector() : m_mepc;
  endtask

  task automatic model_edge();
    bit t, r, irq_taken, mret_taken;
    logic [31:0] p, pend;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_msip = 0;
      m_mie_reg = 0; m_mepc = 0; m_mcause = 0; m_mtvec = c_vec & 32'hFFFF_FFFC;
      m_hist = {};
      for (int i = 0; i < c_sync; i++) m_hist.push_back(1'b0);
      return;
    end
    model_comb(t, r, p, irq_taken, mret_taken);
    pend = model_mip() & m_mie_reg;
    if (t) begin
      m_mepc = x_pc;
      if (irq_taken)
        m_mcause = 32'h8000_0000 | (pend[11] ? 32'd11 : (pend[3] ? 32'd3 : 32'd7));
      else
        m_mcause = {28'b0, x_cause};
      m_mpie = m_mie;
      m_mie  = 0;
    end else if (mret_taken) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (x_valid && !x_stall && !x_kill && x_is_csr) begin
      case (x_csr_sel)
        12'h300: begin m_mie = x_csr_wval[3]; m_mpie = x_csr_wval[7]; end
        12'h304: m_mie_reg = x_csr_wval & 32'h888;
        12'h341: m_mepc = x_csr_wval & 32'hFFFF_FFFE;
        12'h342: m_mcause = x_csr_wval;
        12'h344: m_msip = x_csr_wval[3];
`ifdef KMKZ_MTVEC_EN
        12'h305: m_mtvec = x_csr_wval & 32'hFFFF_FFFC;
`endif
        default: ;
      endcase
    end
    m_hist.push_front(irq);
    void'(m_hist.pop_back());
  endtask

  task automatic idle();
    x_stall = 0; x_kill = 0; x_valid = 0; x_pc = 0;
    x_exception = 0; x_cause = 0; x_is_mret = 0; x_is_csr = 0;
    x_csr_sel = 0; x_csr_wval = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
    @(negedge clk);
    idle();
    x_valid = 1; x_is_csr = 1; x_csr_sel = sel; x_csr_wval = val; x_pc = 32'h50;
    tick();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle(); irq = 0; timer_irq = 0; rst = 1;
    tick(); tick();
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (mstatus !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", mstatus, 32'h1800); end
    checks++; if (mip !== 0) begin errors++; $display("FAIL reset_mip got %h exp 0", mip); end
    checks++; if (mie !== 0) begin errors++; $display("FAIL reset_mie got %h exp 0", mie); end
    checks++; if (mepc !== 0) begin errors++; $display("FAIL reset_mepc got %h exp 0", mepc); end
    checks++; if (mcause !== 0) begin errors++; $display("FAIL reset_mcause got %h exp 0", mcause); end
    checks++; if (redirect !== 0) begin errors++; $display("FAIL reset_redirect got %b exp 0", redirect); end
  endtask

  task automatic test_exception();
    csr_write(12'h300, 32'h8);
    @(negedge clk);
    x_valid = 1; x_pc = 32'h100; x_exception = 1; x_cause = 4'd11;
    #1;
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL exc_trap got %b exp 1", trap); end
    checks++; if (redirect_pc !== c_vec) begin errors++; $display("FAIL exc_redirect_pc got %h exp %h", redirect_pc, c_vec); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if (mepc !== 32'h100) begin errors++; $display("FAIL exc_mepc got %h exp 100", mepc); end
    checks++; if (mcause !== 32'd11) begin errors++; $display("FAIL exc_mcause got %h exp b", mcause); end
    checks++; if (mstatus !== 32'h1880) begin errors++; $display("FAIL exc_mstatus got %h exp 1880", mstatus); end
  endtask

  task automatic test_external_irq();
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    @(negedge clk); irq = 1;
    tick();
    checks++; if (mip[11] !== 1'b0) begin errors++; $display("FAIL irq_sync_stage1 got %b exp 0", mip[11]); end
    tick();
    checks++; if (mip[11] !== 1'b1) begin errors++; $display("FAIL irq_sync_stage2 got %b exp 1", mip[11]); end
    @(negedge clk);
    x_valid = 1; x_pc = 32'h200; irq = 0;
    #1;
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL irq_trap got %b exp 1", trap); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if (mcause !== 32'h8000000B) begin errors++; $display("FAIL irq_mcause got %h exp 8000000b", mcause); end
    checks++; if (mepc !== 32'h200) begin errors++; $display("FAIL irq_mepc got %h exp 200", mepc); end
  endtask

  task automatic test_mret();
    csr_write(12'h341, 32'h105);
    tick();
    checks++; if (mepc !== 32'h104) begin errors++; $display("FAIL mret_mepc_write got %h exp 104", mepc); end
    @(negedge clk);
    x_valid = 1; x_is_mret = 1; x_pc = 32'h30;
    #1;
    checks++; if (redirect !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL mret_redirect got %b/%b exp 1/0", redirect, trap); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL mret_pc got %h exp 104", redirect_pc); end
    tick();
    @(negedge clk); idle(); #1;
    checks++; if (mstatus !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 1888", mstatus); end
  endtask

  task automatic test_exc_vs_csr();
    @(negedge clk);
    x_valid = 1; x_pc = 32'h300; x_exception = 1; x_cause = 4'd2;
    x_is_csr = 1; x_csr_sel = 12'h341; x_csr_wval = 32'hDEAD0000;
    tick();
    @(negedge clk); idle(); #1;
    checks++; if (mepc !== 32'h300) begin errors++; $display("FAIL exc_csr_mepc got %h exp 300", mepc); end
    checks++; if (mcause !== 32'd2) begin errors++; $display("FAIL exc_csr_mcause got %h exp 2", mcause); end
  endtask

  task automatic test_priority_stall();
    csr_write(12'h304, 32'h888);
    csr_write(12'h344, 32'h8);
    @(negedge clk); timer_irq = 1;
    csr_write(12'h300, 32'h8);
    @(negedge clk);
    x_valid = 1; x_stall = 1; x_pc = 32'h400;
    #1;
    checks++; if (redirect !== 1'b0 || trap !== 1'b0) begin errors++; $display("FAIL stall_redirect got %b/%b exp 0/0", redirect, trap); end
    tick();
    checks++; if (mepc !== 32'h300 || mcause !== 32'd2) begin errors++; $display("FAIL stall_hold got %h/%h exp 300/2", mepc, mcause); end
    checks++; if (mstatus !== 32'h1808) begin errors++; $display("FAIL stall_mstatus got %h exp 1808", mstatus); end
    checks++; if (mip !== 32'h88) begin errors++; $display("FAIL prio_mip got %h exp 88", mip); end
    @(negedge clk); x_stall = 0;
    tick();
    checks++; if (mcause !== 32'h80000003) begin errors++; $display("FAIL prio_mcause got %h exp 80000003", mcause); end
    checks++; if (mepc !== 32'h400) begin errors++; $display("FAIL prio_mepc got %h exp 400", mepc); end
    @(negedge clk); idle(); timer_irq = 0;
    csr_write(12'h344, 32'h0);
    csr_write(12'h304, 32'h0);
  endtask

  task automatic test_random();
    logic [11:0] sels [7] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h305, 12'h340};
    bit          e_trap, e_redir, e_irq, e_mret;
    logic [31:0] e_pc;
    @(negedge clk); idle(); irq = 0; timer_irq = 0; rst = 1;
    tick();
    @(negedge clk); rst = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) irq = ~irq;
      if ($urandom_range(7) == 0) timer_irq = ~timer_irq;
      x_valid     = ($urandom_range(4) != 0);
      x_stall     = ($urandom_range(4) == 0);
      x_kill      = ($urandom_range(7) == 0);
      x_pc        = $urandom & 32'hFFFF_FFFC;
      x_exception = ($urandom_range(9) == 0);
      x_cause     = 4'($urandom);
      x_is_csr    = ($urandom_range(2) == 0);
      x_is_mret   = !x_is_csr && ($urandom_range(6) == 0);
      x_csr_sel   = sels[$urandom_range(6)];
      x_csr_wval  = $urandom;
      #1;
      model_comb(e_trap, e_redir, e_pc, e_irq, e_mret);
      checks++; if (trap !== e_trap) begin errors++; $display("FAIL rnd_trap cyc %0d got %b exp %b", n, trap, e_trap); end
      checks++; if (redirect !== e_redir) begin errors++; $display("FAIL rnd_redirect cyc %0d got %b exp %b", n, redirect, e_redir); end
      if (e_redir) begin
        checks++; if (redirect_pc !== e_pc) begin errors++; $display("FAIL rnd_redirect_pc cyc %0d got %h exp %h", n, redirect_pc, e_pc); end
      end
      tick();
      checks++; if (mstatus !== model_mstatus()) begin errors++; $display("FAIL rnd_mstatus cyc %0d got %h exp %h", n, mstatus, model_mstatus()); end
      checks++; if (mip !== model_mip()) begin errors++; $display("FAIL rnd_mip cyc %0d got %h exp %h", n, mip, model_mip()); end
      checks++; if (mie !== m_mie_reg) begin errors++; $display("FAIL rnd_mie cyc %0d got %h exp %h", n, mie, m_mie_reg); end
      checks++; if (mepc !== m_mepc) begin errors++; $display("FAIL rnd_mepc cyc %0d got %h exp %h", n, mepc, m_mepc); end
      checks++; if (mcause !== m_mcause) begin errors++; $display("FAIL rnd_mcause cyc %0d got %h exp %h", n, mcause, m_mcause); end
`ifdef KMKZ_MTVEC_EN
      checks++; if (mtvec !== m_mtvec) begin errors++; $display("FAIL rnd_mtvec cyc %0d got %h exp %h", n, mtvec, m_mtvec); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_external_irq();
    test_mret();
    test_exc_vs_csr();
    test_priority_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kmkz_exceptions.md
Name: kmkz_exceptions

Overview:
Machine-mode trap controller for the Kamikaze-uRV core; the producer end of the CSR unit's mstatus/mip/mie/mepc/mcause read inputs, and the consumer of its write value. It owns those registers and tracks interrupt sources. It decides, per execute-stage instruction, whether an exception, interrupt or MRET redirects the fetch stream, and updates trap state on the next clock edge.

Parameters:
TRAP_VECTOR, 32'h00000008, fixed trap handler address (mtvec reset value when KMKZ_MTVEC_EN).
IRQ_SYNC_STAGES, 2, synchronizer depth for irq_i (>=1).

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
x_stall_i  in  1  execute stage stalled
x_kill_i  in  1  execute instruction squashed
x_valid_i  in  1  execute holds a real instruction
x_pc_i  in  32  PC of execute instruction
x_exception_i  in  1  synchronous exception raised by execute instruction
x_exception_cause_i  in  4  exception code (e.g. 2 illegal, 3 ebreak, 11 ecall)
x_is_mret_i  in  1  execute instruction is MRET
x_is_csr_i  in  1  execute instruction is CSR op
x_csr_sel_i  in  12  CSR address
x_csr_write_value_i  in  32  new CSR value from CSR unit
irq_i  in  1  external interrupt, asynchronous, level
timer_irq_i  in  1  timer interrupt, synchronous, level
x_redirect_o  out  1  fetch redirect this cycle (trap or MRET)
x_redirect_pc_o  out  32  redirect target
x_trap_o  out  1  trap taken this cycle
csr_mstatus_o  out  32
csr_mip_o  out  32
csr_mie_o  out  32
csr_mepc_o  out  32
csr_mcause_o  out  32

Behaviour:
- Reset (rst_i sampled high at clk_i edge): MIE=MPIE=0; mie=0; mepc=0; mcause=0; MSIP=0; sync chain=0. Reads after reset: csr_mstatus_o=32'h00001800 (MPP=2'b11 hardwired), csr_mip_o=0. Reset wins over every concurrent event.
- go = !x_stall_i && !x_kill_i && x_valid_i.
- csr_mstatus_o = {19'b0, 2'b11, 3'b0, MPIE, 3'b0, MIE, 3'b0}.
- csr_mip_o: bit11 = last sync stage of irq_i; bit7 = timer_irq_i; bit3 = MSIP.
- csr_mie_o: bits 11/7/3 only, others 0.
- pend = mip & mie; irq_ok = MIE && (pend != 0).
- Priority, combinational, same cycle:
  1. exc = go && x_exception_i
  2. irq = go && !x_exception_i && irq_ok
  3. mret = go && !exc && !irq && x_is_mret_i
  4. CSR write
- x_trap_o = exc | irq.
- x_redirect_o = x_trap_o | mret.
- x_redirect_pc_o = trap vector on trap, else mepc.
- Next edge on exc: mepc <= x_pc_i; mcause <= {28'b0, x_exception_cause_i}; MPIE <= MIE; MIE <= 0.
- Next edge on irq: mepc <= x_pc_i (instruction not executed, re-run after MRET); mcause <= {1'b1, 27'b0, code}; MPIE <= MIE; MIE <= 0.
- IRQ code priority: external 11 > software 3 > timer 7.
- Next edge on mret: MIE <= MPIE; MPIE <= 1.
- CSR write (go && x_is_csr_i, no trap that cycle):
  - 0x300 mstatus: bits 3,7 only.
  - 0x304 mie: bits 3,7,11.
  - 0x341 mepc: bits 31:1, bit0 forced 0.
  - 0x342 mcause: full 32 bits.
  - 0x344 mip: bit3 (MSIP) only.
  - Other addresses: ignored.
- Trap in same cycle as CSR write: trap update wins, CSR write discarded.
- Stalled or killed instruction: no state change, no redirect.
- Interrupt latency: irq_i to csr_mip_o bit11 is IRQ_SYNC_STAGES cycles; timer is combinational.
- Levels are not latched; source deassertion before being taken cancels the interrupt.
- No nesting: MIE=0 inside handler until MRET or a CSR write.

Optional Feature:
KMKZ_MTVEC_EN:
- Defined: writable mtvec at 0x305, bits 31:2, bits 1:0 read 0, reset TRAP_VECTOR; trap vector = mtvec. Adds output csr_mtvec_o [31:0].
- Undefined: vector fixed at TRAP_VECTOR; writes to 0x305 ignored; no csr_mtvec_o port.

Test Plan:
- Reset, then read all CSR outputs -> mstatus 32'h1800, others 0, x_redirect_o=0.
- MIE=1; ecall (cause 11) at pc 32'h100, go=1 -> same cycle x_trap_o=1, redirect_pc=32'h8; next cycle mepc=32'h100, mcause=11, mstatus=32'h1880.
- mie=32'h800, MIE=1, raise irq_i -> trap on first go cycle after 2 sync cycles; mcause=32'h8000000B, mepc=x_pc_i.
- Inside handler, MRET with mepc=32'h104 -> redirect to 32'h104; next cycle MIE=1, MPIE=1.
- Exception and CSR write to mscratch-adjacent mepc in same go cycle -> mepc=trap PC, not CSR value.
- MSIP and MTIP both pending and enabled -> mcause code 3; x_stall_i=1 holds everything unchanged.
